control_unit_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle processor control unit.
- Accepts one instruction word per valid/ready handshake and decodes opcode, address and immediate fields.
- Sequences memory read/write transactions with an acknowledge and timeout, owns the A/B operand registers feeding the external ALU, and latches carry/zero flags.
- Sits between the instruction register/fetch logic, data memory and the combinational ALU.

---
 rtl/cu_pkg.sv | 45 ++++
 rtl/cu_mem_timer.sv | 41 ++++
 rtl/control_unit_mc.sv | 153 +++++++++++++++
 tb/tb_control_unit_mc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, FSM states and field-offset helpers for control_unit_mc
package cu_pkg;

  // Default geometry of the instruction word
  localparam int IW_DEF     = 16;
  localparam int OP_W_DEF   = 3;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 9;
  localparam int TIMEOUT_DEF = 15;

  // Opcode encodings
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_LD   = 3'd2;
  localparam logic [2:0] OP_ST   = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_MOVB = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_EXEC,
    S_DONE,
    S_HALT
  } state_t;

  // Field offsets: opcode at the top, address below it, immediate at the bottom
  function automatic int op_msb(input int iw);
    return iw - 1;
  endfunction

  function automatic int addr_msb(input int iw, input int op_w);
    return iw - 1 - op_w;
  endfunction

  // Width of the reserved gap between the address and immediate fields
  function automatic int rsv_width(input int iw, input int op_w, input int addr_w, input int data_w);
    return iw - op_w - addr_w - data_w;
  endfunction

endpackage

// File: rtl/cu_mem_timer.sv
// rtl/cu_mem_timer.sv - wait-cycle counter with timeout compare for memory transactions
module cu_mem_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic ack,
  output logic expired
);

  // Counter only needs to reach TIMEOUT-1 (cycles already waited before the current one)
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Final waiting cycle without ack ends the transaction; an ack in that cycle wins
  assign expired = (TIMEOUT != 0) && active && !ack && (cnt_q == LIMIT);

  // Next count: clear on entry, advance on each unacknowledged waiting cycle
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (active && !ack && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multi-cycle control unit: decode, memory sequencing, operand and flag registers
module control_unit_mc
  import cu_pkg::*;
#(
  parameter int IW      = IW_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     ir_data,
  input  logic              ir_valid,
  output logic              ir_ready,
  input  logic [DATA_W-1:0] data_out,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              cy,
  input  logic              zero,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  output logic              rd,
  output logic              wr,
  output logic [OP_W-1:0]   opcode,
  output logic              cy_q,
  output logic              zero_q,
  output logic              done,
  output logic              err,
  output logic              halted
);

  localparam int OP_MSB   = op_msb(IW);
  localparam int ADDR_MSB = addr_msb(IW, OP_W);
  localparam int RSV_W    = rsv_width(IW, OP_W, ADDR_W, DATA_W);

  state_t            state_q;
  logic [OP_W-1:0]   opcode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] imm_q;
  logic              rsv_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              cy_flag_q, zero_flag_q, err_q;
  logic              rsv_in, tmr_expired;

  // Reserved gap must be zero; only exists when the word is wider than the fields
  if (RSV_W > 0) begin : g_rsv
    assign rsv_in = |ir_data[DATA_W +: RSV_W];
  end else begin : g_no_rsv
    assign rsv_in = 1'b0;
  end

  cu_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (state_q == S_DECODE),
    .active (rd | wr),
    .ack    (mem_ack),
    .expired(tmr_expired)
  );

  // Moore outputs decoded purely from the state register
  assign ir_ready = (state_q == S_IDLE);
  assign rd       = (state_q == S_MEM_RD);
  assign wr       = (state_q == S_MEM_WR);
  assign done     = (state_q == S_DONE);
  assign halted   = (state_q == S_HALT);
  assign A        = a_q;
  assign B        = b_q;
  assign data_in  = a_q;
  assign addr     = addr_q;
  assign opcode   = opcode_q;
  assign cy_q     = cy_flag_q;
  assign zero_q   = zero_flag_q;
  assign err      = err_q;

  // Instruction sequencer with its operand, flag and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      addr_q      <= '0;
      imm_q       <= '0;
      rsv_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cy_flag_q   <= 1'b0;
      zero_flag_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ir_valid) begin
            opcode_q <= ir_data[OP_MSB -: OP_W];
            addr_q   <= ir_data[ADDR_MSB -: ADDR_W];
            imm_q    <= ir_data[DATA_W-1:0];
            rsv_q    <= rsv_in;
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (rsv_q) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            case (opcode_q)
              OP_LDI:  begin a_q <= imm_q; state_q <= S_DONE; end
              OP_MOVB: begin b_q <= a_q;   state_q <= S_DONE; end
              OP_LD, OP_ADD, OP_SUB: state_q <= S_MEM_RD;
              OP_ST:   state_q <= S_MEM_WR;
              OP_HALT: state_q <= S_HALT;
              default: state_q <= S_DONE;
            endcase
          end
        end
        S_MEM_RD: begin
          if (mem_ack) begin
            if (opcode_q == OP_LD) begin
              a_q     <= data_out;
              state_q <= S_DONE;
            end else begin
              b_q     <= data_out;
              state_q <= S_EXEC;
            end
          end else if (tmr_expired) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_MEM_WR: begin
          if (mem_ack) begin
            state_q <= S_DONE;
          end else if (tmr_expired) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_EXEC: begin
          a_q         <= alu_out;
          cy_flag_q   <= cy;
          zero_flag_q <= zero;
          state_q     <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// tb/tb_control_unit_mc.sv - directed self-checking bench for control_unit_mc
module tb_control_unit_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ir_data;
  logic        ir_valid;
  logic        ir_ready;
  logic [8:0]  data_out;
  logic        mem_ack;
  logic [8:0]  alu_out;
  logic        cy, zero;
  logic [8:0]  A, B, data_in;
  logic [2:0]  addr, opcode;
  logic        rd, wr, cy_q, zero_q, done, err, halted;

  int n_assert = 0;
  int n_fail   = 0;
  int wcnt;

  always #5 clk = ~clk;

  control_unit_mc dut (
    .clk(clk), .rst_n(rst_n), .ir_data(ir_data), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .data_out(data_out), .mem_ack(mem_ack), .alu_out(alu_out), .cy(cy), .zero(zero),
    .A(A), .B(B), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr), .opcode(opcode),
    .cy_q(cy_q), .zero_q(zero_q), .done(done), .err(err), .halted(halted)
  );

  // Reference ALU: 9-bit add/sub with carry/borrow out
  logic [9:0] alu_full;
  always_comb begin
    alu_full = '0;
    if (opcode == 3'd5) alu_full = {1'b0, A} - {1'b0, B};
    else                alu_full = {1'b0, A} + {1'b0, B};
    alu_out = alu_full[8:0];
    cy      = alu_full[9];
    zero    = (alu_full[8:0] == 9'd0);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for the acceptance edge
  task automatic issue(input logic [15:0] w);
    ir_data  = w;
    ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ir_data = '0; ir_valid = 1'b0; data_out = '0; mem_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ir_ready", 16'(ir_ready), 16'd1);
    chk("rst_A", 16'(A), 16'd0);
    chk("rst_B", 16'(B), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_strobes", {13'd0, rd, wr, done}, 16'd0);

    // LDI 5: DONE after 2 edges
    issue(16'b001_000_0_000000101);
    chk("ldi_busy", {14'd0, ir_ready, done}, 16'd0);
    tick();
    chk("ldi_done", 16'(done), 16'd1);
    chk("ldi_A", 16'(A), 16'd5);
    tick();
    chk("ldi_done_pulse", 16'(done), 16'd0);
    chk("ldi_ready_back", 16'(ir_ready), 16'd1);

    // LD addr 3 with ack in third wait cycle
    issue({3'd2, 3'd3, 1'b0, 9'd0});
    tick();
    chk("ld_rd1", {12'd0, rd, addr}, 16'b1_011);
    tick();
    chk("ld_rd2", {12'd0, rd, addr}, 16'b1_011);
    tick();
    chk("ld_rd3", {12'd0, rd, addr}, 16'b1_011);
    mem_ack = 1'b1; data_out = 9'h1A5;
    tick();
    mem_ack = 1'b0;
    chk("ld_rd_off", 16'(rd), 16'd0);
    chk("ld_A", 16'(A), 16'h1A5);
    chk("ld_done", 16'(done), 16'd1);
    tick();

    // ADD: A=1FF + mem 1 -> 0, carry and zero
    issue({3'd1, 3'd0, 1'b0, 9'h1FF});
    tick(); tick();
    issue({3'd4, 3'd2, 1'b0, 9'd0});
    tick();
    chk("add_rd", 16'(rd), 16'd1);
    mem_ack = 1'b1; data_out = 9'd1;
    tick();
    mem_ack = 1'b0;
    chk("add_B", 16'(B), 16'd1);
    chk("add_flags_hold", {14'd0, cy_q, zero_q}, 16'd0);
    tick();
    chk("add_A", 16'(A), 16'd0);
    chk("add_flags", {14'd0, cy_q, zero_q}, 16'b11);
    chk("add_done", 16'(done), 16'd1);
    tick();

    // SUB: 3 - 5 -> 1FE with borrow, not zero
    issue({3'd1, 3'd0, 1'b0, 9'd3});
    tick(); tick();
    issue({3'd5, 3'd1, 1'b0, 9'd0});
    tick();
    mem_ack = 1'b1; data_out = 9'd5;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("sub_A", 16'(A), 16'h1FE);
    chk("sub_flags", {14'd0, cy_q, zero_q}, 16'b10);
    tick();

    // MOVB: B <= A
    issue({3'd6, 3'd0, 1'b0, 9'd0});
    tick();
    chk("movb_B", 16'(B), 16'h1FE);
    chk("movb_done", 16'(done), 16'd1);
    tick();

    // ST addr 5 without ack: wr held exactly 15 cycles, then error
    chk("st_err_pre", 16'(err), 16'd0);
    issue({3'd3, 3'd5, 1'b0, 9'd0});
    tick();
    chk("st_wr_data", {3'd0, wr, addr, data_in}, {3'd0, 1'b1, 3'd5, 9'h1FE});
    wcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wr) break;
      wcnt++;
      tick();
    end
    chk("st_wr_cycles", 16'(wcnt), 16'd15);
    chk("st_err", 16'(err), 16'd1);
    chk("st_done", 16'(done), 16'd1);
    chk("st_A_kept", 16'(A), 16'h1FE);
    tick();

    // Asynchronous reset in the middle of a read
    issue({3'd2, 3'd1, 1'b0, 9'd0});
    tick();
    chk("arst_rd_pre", 16'(rd), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd", 16'(rd), 16'd0);
    chk("arst_AB", {A[7:0], B[7:0]}, 16'd0);
    chk("arst_err", 16'(err), 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_ready", 16'(ir_ready), 16'd1);

    // NOP with reserved bit set flags an error
    issue(16'b000_000_1_000000000);
    tick();
    chk("rsv_err", 16'(err), 16'd1);
    chk("rsv_done", 16'(done), 16'd1);
    tick();

    // HALT then an offered LDI is ignored
    issue({3'd7, 3'd0, 1'b0, 9'd0});
    tick();
    chk("halt_halted", 16'(halted), 16'd1);
    ir_data = {3'd1, 3'd0, 1'b0, 9'd7};
    ir_valid = 1'b1;
    tick(); tick(); tick();
    ir_valid = 1'b0;
    chk("halt_ready", {14'd0, halted, ir_ready}, 16'b10);
    chk("halt_A", 16'(A), 16'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("halt_reset", {14'd0, halted, ir_ready}, 16'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
